// File: rtl/orientation_rx_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : orientation_rx_if                                  |
// | Description : Serial cube-state link between MCU and receiver,   |
// |               plus the committed-state/status side it produces.  |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
interface orientation_rx_if #(
    parameter int FRAME_BITS = 162
);
    logic                  sck;
    logic                  sdi;
    logic                  load;
    logic                  render_busy;
    logic [FRAME_BITS-1:0] orientation;
    logic                  frame_valid;
    logic                  frame_error;
    logic [1:0]            err_code;
    logic                  pending;
    logic [7:0]            frame_count;

    // MCU / renderer side: drives the serial link and render_busy
    modport master (
        output sck, sdi, load, render_busy,
        input  orientation, frame_valid, frame_error, err_code, pending, frame_count
    );

    // Receiver side
    modport slave (
        input  sck, sdi, load, render_busy,
        output orientation, frame_valid, frame_error, err_code, pending, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/orientation_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : orientation_rx                                     |
// | Description : Receives a serial cube-state frame from an MCU,    |
// |               validates length and colour codes, and commits it  |
// |               to the orientation register when the LED renderer  |
// |               is not mid-refresh.                                |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module orientation_rx #(
    parameter int FRAME_BITS  = 162,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic       clk,
    input  wire logic       reset,
    orientation_rx_if.slave bus
);
    localparam int c_FIELDS = FRAME_BITS / 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Synchroniser chain, one 3-bit lane per stage: {load, sdi, sck}
    logic [2:0]            r_sync [SYNC_STAGES];
    logic [2:0]            r_prev;
    logic [2:0]            w_sync;
    logic                  r_sck_rise;
    logic                  r_load_rise;
    logic                  r_load_fall;

    state_t                r_state;
    state_t                w_next;
    logic                  w_shift;
    logic                  w_clr_cnt;
    logic                  w_commit;
    logic                  w_error;
    logic [1:0]            w_err_val;
    logic                  w_len_bad;
    logic                  w_colour_bad;

    logic [FRAME_BITS-1:0] r_shreg;
    logic [7:0]            r_bit_cnt;
    logic [FRAME_BITS-1:0] r_orientation;
    logic                  r_frame_valid;
    logic                  r_frame_error;
    logic [1:0]            r_err_code;
    logic [7:0]            r_frame_count;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Synchronise the MCU signals and register their edge pulses; the sdi
    // copy in r_prev lines up with the registered sck rise pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 3'b000;
            end
            r_prev      <= 3'b000;
            r_sck_rise  <= 1'b0;
            r_load_rise <= 1'b0;
            r_load_fall <= 1'b0;
        end else begin
            r_sync[0] <= {bus.load, bus.sdi, bus.sck};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev      <= w_sync;
            r_sck_rise  <= w_sync[0] & ~r_prev[0];
            r_load_rise <= w_sync[2] & ~r_prev[2];
            r_load_fall <= ~w_sync[2] & r_prev[2];
        end
    end

    // Frame checks evaluated on the assembled shift register
    always_comb begin
        w_len_bad    = ({24'd0, r_bit_cnt} != 32'(FRAME_BITS));
        w_colour_bad = 1'b0;
        for (int i = 0; i < c_FIELDS; i++) begin
            if (r_shreg[3*i +: 3] > 3'b101) begin
                w_colour_bad = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state and datapath controls
    always_comb begin
        w_next    = r_state;
        w_shift   = 1'b0;
        w_clr_cnt = 1'b0;
        w_commit  = 1'b0;
        w_error   = 1'b0;
        w_err_val = 2'b00;
        case (r_state)
            IDLE: begin
                if (r_load_rise) begin
                    w_next    = SHIFT;
                    w_clr_cnt = 1'b1;
                end
            end
            SHIFT: begin
                // A final sck rise coinciding with load fall is still taken
                w_shift = r_sck_rise;
                if (r_load_fall) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                w_next = IDLE;
                if (w_len_bad) begin
                    w_error   = 1'b1;
                    w_err_val = 2'b01;
                end else if (w_colour_bad) begin
                    w_error   = 1'b1;
                    w_err_val = 2'b10;
                end else if (bus.render_busy) begin
                    w_next = HOLD;
                end else begin
                    w_commit = 1'b1;
                end
            end
            HOLD: begin
                // A new frame starting beats a late commit of the held one
                if (r_load_rise) begin
                    w_next    = SHIFT;
                    w_clr_cnt = 1'b1;
                    w_error   = 1'b1;
                    w_err_val = 2'b11;
                end else if (!bus.render_busy) begin
                    w_next   = IDLE;
                    w_commit = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Shift register, bit counter, committed state and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg       <= '0;
            r_bit_cnt     <= 8'd0;
            r_orientation <= '0;
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
            r_err_code    <= 2'b00;
            r_frame_count <= 8'd0;
        end else begin
            r_frame_valid <= w_commit;
            r_frame_error <= w_error;
            if (w_clr_cnt) begin
                r_bit_cnt <= 8'd0;
            end else if (w_shift) begin
                r_shreg <= {r_shreg[FRAME_BITS-2:0], r_prev[1]};
                if (r_bit_cnt != 8'hFF) begin
                    r_bit_cnt <= r_bit_cnt + 8'd1;
                end
            end
            if (w_commit) begin
                r_orientation <= r_shreg;
                r_frame_count <= r_frame_count + 8'd1;
            end
            if (w_error) begin
                r_err_code <= w_err_val;
            end
        end
    end

    assign bus.orientation = r_orientation;
    assign bus.frame_valid = r_frame_valid;
    assign bus.frame_error = r_frame_error;
    assign bus.err_code    = r_err_code;
    assign bus.pending     = (r_state == HOLD);
    assign bus.frame_count = r_frame_count;
endmodule
`default_nettype wire

// File: tb/tb_orientation_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_orientation_rx                                  |
// | Description : Directed self-checking bench for orientation_rx    |
// |               with a frame-outcome scoreboard model.             |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_orientation_rx;
    localparam int FRAME_BITS  = 162;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 4;   // clk cycles per sck half period

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    orientation_rx_if #(.FRAME_BITS(FRAME_BITS)) bus ();

    orientation_rx #(
        .FRAME_BITS (FRAME_BITS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Expected outcome of one frame, in the order frames finish
    typedef struct {
        bit                    is_err;
        logic [1:0]            code;
        logic [FRAME_BITS-1:0] val;
    } outcome_t;

    outcome_t              exp_q[$];
    logic [FRAME_BITS-1:0] exp_orient = '0;
    logic [7:0]            exp_count  = 8'd0;
    logic [1:0]            exp_err    = 2'b00;
    int                    n_tests = 0;
    int                    n_fail  = 0;
    int                    n_valid = 0;
    bit                    rst_at_edge = 1'b0;

    task automatic check(input string name, input logic [FRAME_BITS-1:0] act,
                         input logic [FRAME_BITS-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [FRAME_BITS-1:0] pattern(input int offs, input bit rev);
        logic [FRAME_BITS-1:0] v;
        v = '0;
        for (int i = 0; i < FRAME_BITS / 3; i++) begin
            v[3*i +: 3] = rev ? 3'(5 - (i % 6)) : 3'((i + offs) % 6);
        end
        return v;
    endfunction

    function automatic outcome_t mk(input bit is_err, input logic [1:0] code,
                                    input logic [FRAME_BITS-1:0] val);
        outcome_t o;
        o.is_err = is_err;
        o.code   = code;
        o.val    = val;
        return o;
    endfunction

    task automatic start_frame();
        bus.load = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic send_bits(input logic [FRAME_BITS-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.sdi = v[FRAME_BITS-1-i];
            bus.sck = 1'b0;
            tick(HALF);
            bus.sck = 1'b1;
            tick(HALF);
        end
        bus.sck = 1'b0;
        tick(HALF);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d outcomes outstanding after %0d cycles, expected 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
        tick(4);
    endtask

    always @(posedge clk) rst_at_edge <= reset;

    // Compare process: pulses against the scoreboard, held outputs against the model
    always @(negedge clk) begin
        if (rst_at_edge) begin
            exp_orient = '0;
            exp_count  = 8'd0;
            exp_err    = 2'b00;
            exp_q.delete();
            check("pulses_in_reset", {bus.frame_valid, bus.frame_error}, 0);
        end else begin
            if (bus.frame_valid) begin
                n_valid++;
                n_tests++;
                if (exp_q.size() == 0 || exp_q[0].is_err) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: got frame_valid=1, expected 0");
                end else begin
                    check("commit_value", bus.orientation, exp_q[0].val);
                    exp_orient = exp_q[0].val;
                    exp_count  = exp_count + 8'd1;
                    void'(exp_q.pop_front());
                end
            end
            if (bus.frame_error) begin
                n_tests++;
                if (exp_q.size() == 0 || !exp_q[0].is_err) begin
                    n_fail++;
                    $display("FAIL unexpected_error: got frame_error=1 code %0d, expected 0",
                             bus.err_code);
                end else begin
                    check("error_code", bus.err_code, exp_q[0].code);
                    exp_err = exp_q[0].code;
                    void'(exp_q.pop_front());
                end
            end
            check("orientation", bus.orientation, exp_orient);
            check("frame_count", bus.frame_count, exp_count);
            check("err_code", bus.err_code, exp_err);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FRAME_BITS-1:0] pat;
        logic [FRAME_BITS-1:0] bad;
        int lat;
        int saved_valid;

        bus.sck = 1'b0;
        bus.sdi = 1'b0;
        bus.load = 1'b0;
        bus.render_busy = 1'b0;
        reset = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(2);

        // Reset state
        check("rst_orientation", bus.orientation, 0);
        check("rst_frame_count", bus.frame_count, 0);
        check("rst_err_code", bus.err_code, 0);
        check("rst_pending", bus.pending, 0);

        // Valid frame, field i = i mod 6; also measures commit latency
        pat = pattern(0, 1'b0);
        start_frame();
        send_bits(pat, FRAME_BITS);
        exp_q.push_back(mk(1'b0, 2'b00, pat));
        bus.load = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.frame_valid) break;
        end
        check("latency", lat, SYNC_STAGES + 3);
        wait_drain("t1_drain", 20);
        check("t1_field0", bus.orientation[2:0], 3'd0);
        check("t1_field5", bus.orientation[17:15], 3'd5);
        check("t1_field7", bus.orientation[23:21], 3'd1);
        check("t1_field53", bus.orientation[161:159], 3'd5);
        check("t1_count", bus.frame_count, 8'd1);
        check("t1_valid_pulses", n_valid, 1);

        // 161 bits: length error
        start_frame();
        send_bits(pat, FRAME_BITS - 1);
        exp_q.push_back(mk(1'b1, 2'b01, '0));
        bus.load = 1'b0;
        wait_drain("t2_drain", 20);
        check("t2_err_code", bus.err_code, 2'b01);
        check("t2_count", bus.frame_count, 8'd1);

        // Field 4 = 3'b110: bad colour
        bad = pat;
        bad[14:12] = 3'b110;
        start_frame();
        send_bits(bad, FRAME_BITS);
        exp_q.push_back(mk(1'b1, 2'b10, '0));
        bus.load = 1'b0;
        wait_drain("t3_drain", 20);
        check("t3_err_code", bus.err_code, 2'b10);
        check("t3_valid_pulses", n_valid, 1);

        // Renderer busy across a valid frame: hold, then commit the cycle after release
        pat = pattern(1, 1'b0);
        bus.render_busy = 1'b1;
        start_frame();
        send_bits(pat, FRAME_BITS);
        exp_q.push_back(mk(1'b0, 2'b00, pat));
        saved_valid = n_valid;
        bus.load = 1'b0;
        tick(50);
        check("t4_pending_held", bus.pending, 1'b1);
        check("t4_no_valid_while_busy", n_valid, saved_valid);
        bus.render_busy = 1'b0;
        @(posedge clk);
        #1;
        check("t4_valid_next_cycle", bus.frame_valid, 1'b1);
        check("t4_pending_cleared", bus.pending, 1'b0);
        #1;
        wait_drain("t4_drain", 20);
        check("t4_count", bus.frame_count, 8'd2);

        // New frame while one is pending: overrun, then the new frame commits
        bus.render_busy = 1'b1;
        start_frame();
        send_bits(pattern(2, 1'b0), FRAME_BITS);
        exp_q.push_back(mk(1'b1, 2'b11, '0));
        bus.load = 1'b0;
        tick(20);
        check("t5_pending", bus.pending, 1'b1);
        pat = pattern(0, 1'b1);
        start_frame();
        check("t5_pending_dropped", bus.pending, 1'b0);
        check("t5_err_code", bus.err_code, 2'b11);
        bus.render_busy = 1'b0;
        send_bits(pat, FRAME_BITS);
        exp_q.push_back(mk(1'b0, 2'b00, pat));
        bus.load = 1'b0;
        wait_drain("t5_drain", 20);
        check("t5_count", bus.frame_count, 8'd3);
        check("t5_orientation_field0", bus.orientation[2:0], 3'd5);

        // Reset after bit 80, then a full frame
        start_frame();
        send_bits(pattern(0, 1'b0), 80);
        saved_valid = n_valid;
        reset = 1'b1;
        bus.load = 1'b0;
        bus.sck = 1'b0;
        tick(6);
        reset = 1'b0;
        tick(4);
        check("t6_no_valid", n_valid, saved_valid);
        check("t6_count_cleared", bus.frame_count, 8'd0);
        check("t6_err_cleared", bus.err_code, 2'b00);
        pat = pattern(3, 1'b0);
        start_frame();
        send_bits(pat, FRAME_BITS);
        exp_q.push_back(mk(1'b0, 2'b00, pat));
        bus.load = 1'b0;
        wait_drain("t6_drain", 20);
        check("t6_count", bus.frame_count, 8'd1);
        check("t6_orientation", bus.orientation, pat);

        tick(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
